// File: rtl/id_stage.sv
// Decode stage: splits the instruction into EX/MEM/WB controls, checks the condition code,
// and holds the 15-entry register file (falling-edge write, combinational read).
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic [31:0] PCIn,
  input  logic [31:0] instruction,
  input  logic        writeBackEn,
  input  logic [3:0]  destWB,
  input  logic [31:0] valueWB,
  input  logic        hazard,
  input  logic [3:0]  statusReg,
  output logic        S_UpdateSig,
  output logic        branch,
  output logic        memWriteEn,
  output logic        memReadEn,
  output logic        writeBackEnOut,
  output logic [3:0]  exeCMD,
  output logic [31:0] res1,
  output logic [31:0] res2,
  output logic [31:0] PC,
  output logic [23:0] signedImm24,
  output logic [3:0]  Dest,
  output logic        isImmidiate,
  output logic [11:0] shiftOperand
);

  logic [31:0] r_regs [0:14];

  logic [3:0] w_cond, w_opcode, w_rn, w_rd, w_rm, w_rs2;
  logic [1:0] w_mode;
  logic       w_s;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ok, w_bubble;
  logic       w_s_upd, w_br, w_mw, w_mr, w_wb;
  logic [3:0] w_cmd;

  assign w_cond   = instruction[31:28];
  assign w_mode   = instruction[27:26];
  assign w_opcode = instruction[24:21];
  assign w_s      = instruction[20];
  assign w_rn     = instruction[19:16];
  assign w_rd     = instruction[15:12];
  assign w_rm     = instruction[3:0];
  assign {w_n, w_z, w_c, w_v} = statusReg;

  // Falling-edge write lets the value be read back within the same cycle.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= 32'(i);
    end else if (writeBackEn && destWB != 4'd15) begin
      r_regs[destWB] <= valueWB;
    end
  end

  always_comb begin
    w_s_upd = 1'b0;
    w_br    = 1'b0;
    w_mw    = 1'b0;
    w_mr    = 1'b0;
    w_wb    = 1'b0;
    w_cmd   = 4'b0000;
    case (w_mode)
      2'b00: begin
        w_wb    = 1'b1;
        w_s_upd = w_s;
        case (w_opcode)
          4'b1101: w_cmd = 4'b0001;
          4'b1111: w_cmd = 4'b1001;
          4'b0100: w_cmd = 4'b0010;
          4'b0101: w_cmd = 4'b0011;
          4'b0010: w_cmd = 4'b0100;
          4'b0110: w_cmd = 4'b0101;
          4'b0000: w_cmd = 4'b0110;
          4'b1100: w_cmd = 4'b0111;
          4'b0001: w_cmd = 4'b1000;
          4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; w_s_upd = 1'b1; end
          4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; w_s_upd = 1'b1; end
          default: begin w_wb = 1'b0; w_s_upd = 1'b0; end
        endcase
      end
      2'b01: begin
        w_cmd = 4'b0010;
        w_mr  = w_s;
        w_wb  = w_s;
        w_mw  = ~w_s;
      end
      2'b10:   w_br = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = ~w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = ~w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = ~w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = ~w_v;
      4'b1000: w_cond_ok = w_c & ~w_z;
      4'b1001: w_cond_ok = ~w_c | w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ok = w_z | (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_bubble = ~w_cond_ok | hazard | freeze | flush;

  assign S_UpdateSig    = w_s_upd & ~w_bubble;
  assign branch         = w_br    & ~w_bubble;
  assign memWriteEn     = w_mw    & ~w_bubble;
  assign memReadEn      = w_mr    & ~w_bubble;
  assign writeBackEnOut = w_wb    & ~w_bubble;
  assign exeCMD         = w_bubble ? 4'b0000 : w_cmd;

  // Store data comes from Rd; the mux uses the raw decode so bubbles don't change operands.
  assign w_rs2 = w_mw ? w_rd : w_rm;
  assign res1  = (w_rn  == 4'd15) ? 32'd0 : r_regs[w_rn];
  assign res2  = (w_rs2 == 4'd15) ? 32'd0 : r_regs[w_rs2];

  assign PC           = PCIn;
  assign signedImm24  = instruction[23:0];
  assign Dest         = w_rd;
  assign isImmidiate  = instruction[25];
  assign shiftOperand = instruction[11:0];

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, write/reset sequences, random vs model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst, flush, freeze, hazard, writeBackEn;
  logic [31:0] PCIn, instruction, valueWB;
  logic [3:0]  destWB, statusReg;
  logic        S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEnOut;
  logic [3:0]  exeCMD, Dest;
  logic [31:0] res1, res2, PC;
  logic [23:0] signedImm24;
  logic        isImmidiate;
  logic [11:0] shiftOperand;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .PCIn(PCIn),
    .instruction(instruction), .writeBackEn(writeBackEn), .destWB(destWB),
    .valueWB(valueWB), .hazard(hazard), .statusReg(statusReg),
    .S_UpdateSig(S_UpdateSig), .branch(branch), .memWriteEn(memWriteEn),
    .memReadEn(memReadEn), .writeBackEnOut(writeBackEnOut), .exeCMD(exeCMD),
    .res1(res1), .res2(res2), .PC(PC), .signedImm24(signedImm24), .Dest(Dest),
    .isImmidiate(isImmidiate), .shiftOperand(shiftOperand)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [0:14];
  int          op_cmd [0:15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [3:0] idx);
    return (idx == 4'd15) ? 32'd0 : rf[idx];
  endfunction

  // ARM style: pairs of conditions share a base test, odd codes invert it.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, b;
    {n, z, cc, v} = f;
    b = 1'b0;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cc;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cc && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return (c == 4'd14);
    endcase
    return c[0] ? !b : b;
  endfunction

  // ctrl packs {S_Update, branch, memWrite, memRead, writeBack}.
  task automatic model(input logic [31:0] ins, input logic [3:0] st, input logic stall,
                       output logic [3:0] cmd, output logic [4:0] ctrl, output logic [31:0] r2);
    logic [1:0] mode;
    logic       s;
    int         op;
    mode = ins[27:26];
    s    = ins[20];
    op   = op_cmd[ins[24:21]];
    cmd  = 4'd0;
    ctrl = 5'd0;
    if (mode == 2'd0 && op >= 0) begin
      cmd = 4'(op);
      if (ins[24:21] == 4'd10 || ins[24:21] == 4'd8) ctrl = 5'b10000;
      else ctrl = {s, 4'b0001};
    end else if (mode == 2'd1) begin
      cmd  = 4'd2;
      ctrl = s ? 5'b00011 : 5'b00100;
    end else if (mode == 2'd2) begin
      ctrl = 5'b01000;
    end
    r2 = rd_model((mode == 2'd1 && !s) ? ins[15:12] : ins[3:0]);
    if (!cond_model(ins[31:28], st) || stall) begin
      cmd  = 4'd0;
      ctrl = 5'd0;
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  st;
    logic        hz;
    logic [3:0]  cmd;
    logic [4:0]  ctrl;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [4:0] ctrl_out();
    return {S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEnOut};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 15; i++) rf[i] = 32'(i);
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  ecmd;
    logic [4:0]  ectrl;
    logic [31:0] er2;
    logic        stall;

    for (int i = 0; i < 16; i++) op_cmd[i] = -1;
    op_cmd[13] = 1; op_cmd[15] = 9; op_cmd[4] = 2; op_cmd[5] = 3;
    op_cmd[2] = 4;  op_cmd[6] = 5;  op_cmd[0] = 6; op_cmd[12] = 7;
    op_cmd[1] = 8;  op_cmd[10] = 4; op_cmd[8] = 6;

    vecs[0]  = '{32'hE3A00014, 4'b0000, 1'b0, 4'b0001, 5'b00001, 32'd0, 32'd4};
    vecs[1]  = '{32'hE3A01A01, 4'b0000, 1'b0, 4'b0001, 5'b00001, 32'd0, 32'd1};
    vecs[2]  = '{32'hE0A04000, 4'b0000, 1'b0, 4'b0011, 5'b00001, 32'd0, 32'd0};
    vecs[3]  = '{32'hE5910004, 4'b0000, 1'b0, 4'b0010, 5'b00011, 32'd1, 32'd4};
    vecs[4]  = '{32'hE5812000, 4'b0000, 1'b0, 4'b0010, 5'b00100, 32'd1, 32'd2};
    vecs[5]  = '{32'hEA000003, 4'b0000, 1'b0, 4'b0000, 5'b01000, 32'd0, 32'd3};
    vecs[6]  = '{32'h03A00014, 4'b0000, 1'b0, 4'b0000, 5'b00000, 32'd0, 32'd4};
    vecs[7]  = '{32'h03A00014, 4'b0100, 1'b0, 4'b0001, 5'b00001, 32'd0, 32'd4};
    vecs[8]  = '{32'hE5910004, 4'b0000, 1'b1, 4'b0000, 5'b00000, 32'd1, 32'd4};
    vecs[9]  = '{32'hE5812000, 4'b0000, 1'b1, 4'b0000, 5'b00000, 32'd1, 32'd2};
    vecs[10] = '{32'hE1500001, 4'b0000, 1'b0, 4'b0100, 5'b10000, 32'd0, 32'd1};
    vecs[11] = '{32'hEA000003, 4'b0000, 1'b1, 4'b0000, 5'b00000, 32'd0, 32'd3};

    rst = 1'b1; flush = 1'b0; freeze = 1'b0; hazard = 1'b0; writeBackEn = 1'b0;
    PCIn = 32'h0000_0004; instruction = 32'd0; valueWB = 32'd0; destWB = 4'd0;
    statusReg = 4'd0;
    #3 rst = 1'b0;
    reset_model();

    // Reset contents: R[i] = i, R15 reads 0.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      ins = 32'hE0800000;
      ins[19:16] = 4'(i);
      instruction = ins;
      @(negedge clk); #1;
      check($sformatf("reset_r%0d", i), res1, (i == 15) ? 32'd0 : 32'(i));
    end

    foreach (vecs[k]) begin
      @(posedge clk);
      instruction = vecs[k].instr;
      statusReg   = vecs[k].st;
      hazard      = vecs[k].hz;
      @(negedge clk); #1;
      check($sformatf("vec%0d_cmd", k),  exeCMD,     vecs[k].cmd);
      check($sformatf("vec%0d_ctrl", k), ctrl_out(), vecs[k].ctrl);
      check($sformatf("vec%0d_res1", k), res1,       vecs[k].r1);
      check($sformatf("vec%0d_res2", k), res2,       vecs[k].r2);
    end
    hazard = 1'b0;

    @(posedge clk);
    instruction = 32'hE3A01A01;
    PCIn = 32'h0000_1234;
    @(negedge clk); #1;
    check("mov1_dest", Dest, 32'd1);
    check("mov1_shop", shiftOperand, 32'hA01);
    check("mov1_imm", isImmidiate, 32'd1);
    check("mov1_pc", PC, 32'h1234);
    instruction = 32'hEA000003;
    #1 check("b_imm24", signedImm24, 32'h000003);

    // Writeback then same-cycle read of R1.
    @(posedge clk);
    instruction = 32'hE0810002;
    writeBackEn = 1'b1; destWB = 4'd1; valueWB = 32'hDEADBEEF;
    @(negedge clk); #1;
    rf[1] = 32'hDEADBEEF;
    check("wb_r1", res1, 32'hDEADBEEF);
    @(posedge clk);
    destWB = 4'd15; valueWB = 32'h12345678;
    @(negedge clk); #1;
    writeBackEn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ins = 32'hE0800000;
      ins[19:16] = 4'(i);
      instruction = ins;
      #1 check($sformatf("dest15_r%0d", i), res1, rd_model(4'(i)));
    end

    // Asynchronous reset mid-run.
    @(posedge clk);
    instruction = 32'hE0810002;
    #1 rst = 1'b1;
    #1 check("arst_r1", res1, 32'd1);
    rst = 1'b0;
    reset_model();

    for (int it = 0; it < 300; it++) begin
      @(posedge clk);
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'd14;
      instruction = ins;
      statusReg   = 4'($urandom);
      PCIn        = $urandom;
      hazard      = ($urandom_range(0, 9) == 0);
      freeze      = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      writeBackEn = ($urandom_range(0, 2) == 0);
      destWB      = 4'($urandom);
      valueWB     = $urandom;
      if (writeBackEn && destWB != 4'd15) rf[destWB] = valueWB;
      stall = hazard | freeze | flush;
      model(ins, statusReg, stall, ecmd, ectrl, er2);
      @(negedge clk); #1;
      check("rnd_cmd",   exeCMD, ecmd);
      check("rnd_ctrl",  ctrl_out(), ectrl);
      check("rnd_res1",  res1, rd_model(ins[19:16]));
      check("rnd_res2",  res2, er2);
      check("rnd_pc",    PC, PCIn);
      check("rnd_dest",  Dest, ins[15:12]);
      check("rnd_imm24", signedImm24, ins[23:0]);
      check("rnd_i",     isImmidiate, ins[25]);
      check("rnd_shop",  shiftOperand, ins[11:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
